// File: rtl/fft_frame_sched.sv
// Frame-granular round-robin scheduler in front of a shared FFT/IFFT streaming core.
// Streams whole frames, drains the core on mode changes and re-tags the core output.
module fft_frame_sched #(
   parameter int N   = 1024,
   parameter int DW  = 24,
   parameter int LAT = 19
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          s0_valid,
   input  logic [DW-1:0] s0_data,
   output logic          s0_ready,
   input  logic          s1_valid,
   input  logic [DW-1:0] s1_data,
   output logic          s1_ready,
   output logic [DW-1:0] core_in,
   output logic          core_mode,
   input  logic [DW-1:0] core_out,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   output logic          m_sop,
   output logic          m_eop,
   output logic          m_id,
   output logic          busy,
   output logic          underrun
);
   localparam int CW  = $clog2(N);
   localparam int DCW = $clog2(LAT + 1);
   localparam logic [CW-1:0]  CNT_LAST  = CW'(N - 1);
   localparam logic [DCW-1:0] DCNT_LAST = DCW'(LAT - 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STREAM = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   typedef struct packed {
      logic vld;
      logic sop;
      logic eop;
      logic id;
   } tag_t;

   state_t           state_q, state_d;
   logic             grant_q, grant_d;
   logic             last_id_q, last_id_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [DCW-1:0]   dcnt_q, dcnt_d;
   logic             underrun_q, underrun_d;
   logic [DW-1:0]    core_in_q, core_in_d;
   logic             core_mode_q, core_mode_d;
   logic             s0_ready_q, s0_ready_d;
   logic             s1_ready_q, s1_ready_d;
   logic             busy_q, busy_d;
   tag_t [LAT:0]     tag_q, tag_d;
   tag_t             tag_in_s;

   logic             win_vld_s;
   logic             win_id_s;
   logic             gnt_valid_s;
   logic [DW-1:0]    gnt_data_s;
   logic             pipe_busy_s;

   // Round-robin winner among requesters presenting valid this cycle.
   always_comb begin
      win_vld_s   = s0_valid | s1_valid;
      win_id_s    = (s0_valid & s1_valid) ? ~last_id_q : s1_valid;
      gnt_valid_s = grant_q ? s1_valid : s0_valid;
      gnt_data_s  = grant_q ? s1_data : s0_data;
      pipe_busy_s = 1'b0;
      for (int i = 0; i <= LAT; i++) begin
         pipe_busy_s = pipe_busy_s | tag_q[i].vld;
      end
   end

   // Next-state and datapath decode.
   always_comb begin
      state_d     = state_q;
      grant_d     = grant_q;
      last_id_d   = last_id_q;
      cnt_d       = cnt_q;
      dcnt_d      = dcnt_q;
      underrun_d  = underrun_q;
      core_in_d   = {DW{1'b0}};
      core_mode_d = core_mode_q;
      tag_in_s    = '0;

      case (state_q)
         IDLE: begin
            if (win_vld_s) begin
               grant_d   = win_id_s;
               last_id_d = win_id_s;
               cnt_d     = {CW{1'b0}};
               dcnt_d    = {DCW{1'b0}};
               // Same mode, or nothing left in flight: no need to flush the core.
               if ((win_id_s == core_mode_q) || !pipe_busy_s) begin
                  state_d = STREAM;
               end else begin
                  state_d = DRAIN;
               end
            end else begin
               state_d = IDLE;
            end
         end
         STREAM: begin
            core_in_d    = gnt_valid_s ? gnt_data_s : {DW{1'b0}};
            core_mode_d  = grant_q;
            underrun_d   = underrun_q | ~gnt_valid_s;
            tag_in_s.vld = 1'b1;
            tag_in_s.sop = (cnt_q == {CW{1'b0}});
            tag_in_s.eop = (cnt_q == CNT_LAST);
            tag_in_s.id  = grant_q;
            cnt_d        = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               if (!win_vld_s) begin
                  state_d = IDLE;
               end else if (win_id_s == grant_q) begin
                  state_d   = STREAM;
                  last_id_d = win_id_s;
               end else begin
                  state_d   = DRAIN;
                  dcnt_d    = {DCW{1'b0}};
                  grant_d   = win_id_s;
                  last_id_d = win_id_s;
               end
            end else begin
               state_d = STREAM;
            end
         end
         DRAIN: begin
            if (dcnt_q == DCNT_LAST) begin
               state_d = STREAM;
               cnt_d   = {CW{1'b0}};
            end else begin
               dcnt_d  = dcnt_q + DCW'(1);
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Readys come from next-state registers only, never from valid.
      s0_ready_d = (state_d == STREAM) && (grant_d == 1'b0);
      s1_ready_d = (state_d == STREAM) && (grant_d == 1'b1);
      busy_d     = (state_d != IDLE);
      tag_d      = {tag_q[LAT-1:0], tag_in_s};
   end

   // State, datapath and tag pipeline registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         grant_q     <= 1'b0;
         last_id_q   <= 1'b1;
         cnt_q       <= {CW{1'b0}};
         dcnt_q      <= {DCW{1'b0}};
         underrun_q  <= 1'b0;
         core_in_q   <= {DW{1'b0}};
         core_mode_q <= 1'b0;
         s0_ready_q  <= 1'b0;
         s1_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         tag_q       <= '0;
      end else begin
         state_q     <= state_d;
         grant_q     <= grant_d;
         last_id_q   <= last_id_d;
         cnt_q       <= cnt_d;
         dcnt_q      <= dcnt_d;
         underrun_q  <= underrun_d;
         core_in_q   <= core_in_d;
         core_mode_q <= core_mode_d;
         s0_ready_q  <= s0_ready_d;
         s1_ready_q  <= s1_ready_d;
         busy_q      <= busy_d;
         tag_q       <= tag_d;
      end
   end

   assign s0_ready  = s0_ready_q;
   assign s1_ready  = s1_ready_q;
   assign core_in   = core_in_q;
   assign core_mode = core_mode_q;
   assign busy      = busy_q;
   assign underrun  = underrun_q;
   assign m_valid   = tag_q[LAT].vld;
   assign m_sop     = tag_q[LAT].sop;
   assign m_eop     = tag_q[LAT].eop;
   assign m_id      = tag_q[LAT].id;
   assign m_data    = core_out;
endmodule

// File: doc/fft_frame_sched.md
# fft_frame_sched

Frame-level scheduler for the shared 1024-point streaming transform core (24-bit packed complex samples). Two requesters present whole frames: requester 0 for forward FFT, requester 1 for inverse FFT. The block arbitrates round-robin at frame granularity, streams the granted frame into the core, and drains the core pipeline before any FFT/IFFT mode change. It re-aligns the core output with frame tags: valid, start/end of frame, and requester id.

## Interface
- N, 1024, samples per frame (power of two)
- DW, 24, sample width (packed real/imag)
- LAT, 19, core latency in cycles from a sample on core_in to its result on core_out
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- s0_valid / s1_valid  in  1  requester has a sample
- s0_data / s1_data  in  DW  requester sample
- s0_ready / s1_ready  out  1  sample consumed this cycle
- core_in  out  DW  registered sample to core
- core_mode  out  1  0 = FFT, 1 = IFFT (registered)
- core_out  in  DW  core result
- m_valid  out  1  m_data is a frame sample
- m_data  out  DW  core_out passthrough
- m_sop / m_eop  out  1  first / last sample of output frame
- m_id  out  1  requester id of output frame
- busy  out  1  state != IDLE
- underrun  out  1  sticky: granted requester had valid low mid-frame

## Operation
- States: IDLE, STREAM, DRAIN. Registers: grant (1b), last_id (1b, reset 1), cnt (log2 N), dcnt (for LAT), underrun.
- Arbitration, evaluated in IDLE and on the cycle cnt==N-1:
  - Candidates are requesters with valid high.
  - If both are candidates, pick ~last_id.
  - If one is a candidate, pick it.
- IDLE: a winner latches into grant and last_id.
  - If winner == core_mode, or the pipeline is already drained (no tagged samples in flight), go to STREAM with cnt=0.
  - Otherwise go to DRAIN with dcnt=0.
- STREAM: sN_ready = (grant==N), decoded from registers with no combinational path from valid.
  - Every cycle: core_in <= (valid ? data : 0), core_mode <= grant, and cnt increments.
  - Valid low on the granted requester inserts a zero sample, still counts as a frame position, and sets underrun.
  - At cnt==N-1 with a winner equal to grant: stay in STREAM, cnt=0, no bubble.
  - At cnt==N-1 with a winner different from grant: go to DRAIN.
  - At cnt==N-1 with no winner: go to IDLE.
- DRAIN: both readys low, core_in <= 0, core_mode held. After LAT cycles go to STREAM with the latched grant.
- Tag pipeline: LAT+1-deep shift register of {valid, sop=(cnt==0), eop=(cnt==N-1), id=grant}, loaded in STREAM and zero otherwise. Its head drives m_valid, m_sop, m_eop, m_id.
- Only requester 0 ever sets m_id=0 and only requester 1 sets m_id=1. Output frames never interleave.

## Timing
- Reset values: all readys 0, core_in 0, core_mode 0, m_valid/m_sop/m_eop/m_id 0, busy 0, underrun 0, state IDLE, cnt 0, last_id 1, tag pipeline cleared.
- Request to first ready: valid sampled in IDLE at cycle t gives ready high at t+1, plus LAT cycles when a DRAIN is required.
- Sample latency: a sample accepted at cycle t appears on core_in at t+1 and on m_data with m_valid at t+1+LAT.
- Back-to-back same-mode frames: continuous ready for 2N cycles, and m_eop of frame k is immediately followed by m_sop of frame k+1.
- Mode switch gap: exactly LAT cycles with both readys low between the last sample of one frame and the first sample of the next.
- Simultaneous valid at a decision point resolves round-robin as above. Decisions are made only at frame boundaries; a mid-frame request from the other requester waits.
- Reset mid-operation aborts immediately. In-flight tags are cleared, so no m_valid is emitted for aborted samples, and the next grant starts at cnt=0.
- underrun clears only on reset.

## Test plan
- Single FFT frame: s0_valid held with data=index for 1024 cycles from cycle 2. Expect s0_ready from cycle 3 and m_sop at cycle 3+1+19=23. Expect m_eop 1023 cycles later, m_id=0, core_mode=0 throughout, and m_data equal to the core reference output.
- Back-to-back FFT frames (2048 samples): ready never drops, m_valid is continuous for 2048 cycles, and m_sop pulses exactly twice, 1024 cycles apart.
- FFT then IFFT, s1_valid rising mid-frame: s1_ready rises exactly 19 cycles after s0_ready falls, core_mode flips on the first s1 sample, and the second output frame has m_id=1.
- Simultaneous s0_valid and s1_valid out of reset: requester 0 is granted first, then requester 1 (with DRAIN), then requester 0 again if both stay valid.
- Underrun: drop s0_valid for 3 cycles mid-frame. Expect 3 zero samples on core_in, underrun=1 sticky, and the frame length still 1024 with m_eop at the original position.
- Reset at sample 500: all outputs return to reset values asynchronously and no m_valid follows. A new s1 frame after reset has its first output at request+1+1+19 cycles, with no DRAIN because the pipeline is empty.
